pdu_ctrl_pl: RTL
================

# pdu_ctrl_pl

Parametrised program-debug unit controlling the pipelined CPU. It debounces the board's run/step/valid buttons and gates the CPU through a clock enable rather than a derived clock. It supports multi-cycle stepping and a software-loaded PC breakpoint, and serves the memory-mapped IO bus (LED, switch handshake, display, breakpoint). It drives a scanned hex display whose digit count and data width are parameters.

## Interface
- DATA_W, 32, width of IO data, PC and display word
- IN_W, 5, switch/LED width; in[IN_W-1:0] is also the step count
- DIGITS, 8, scanned hex digits; 2 ≤ DIGITS, 4*DIGITS ≤ DATA_W
- SCAN_DIV, 16, clk cycles per display digit
- DB_CYCLES, 4, cycles an input must be stable to be accepted
- clk  in  1  single system clock; CPU runs on clk qualified by cpu_en
- rst  in  1  asynchronous, active-low reset
- run, step, valid  in  1  raw button/switch inputs
- in  in  IN_W  switch value
- pc  in  DATA_W  CPU fetch PC, for the breakpoint compare
- view_data  in  DATA_W  debug word selected externally by check, shown while paused
- io_addr  in  8  IO address
- io_dout  in  DATA_W  CPU write data
- io_we  in  1  CPU IO write strobe, one cycle
- io_din  out  DATA_W  IO read data, combinational on io_addr
- cpu_en  out  1  CPU clock enable
- halted  out  1  breakpoint hit
- check  out  2  paused-view selector
- out0  out  IN_W  LED register
- an  out  $clog2(DIGITS)  active digit index
- seg  out  4  hex nibble of active digit
- ready  out  1  switch data pending for CPU

## Operation
- Input conditioning, identical per input: 2-flop synchroniser, then stability counter. The filtered level changes only after DB_CYCLES consecutive equal samples. A rising edge of the filtered level gives a one-cycle pulse (run_p, step_p, valid_p).
- Modes:
  - RUN: filtered run = 1 and not halted.
  - PAUSED: filtered run = 0.
  - HALT: filtered run = 1 and halted.
- cpu_en:
  - RUN: cpu_en = 1, except when brk_valid && pc == brk_addr. That compare is combinational and forces cpu_en = 0 in the same cycle; halted is set on the next edge.
  - PAUSED: a step_p loads step_cnt with in; a value of 0 is treated as 1. cpu_en = 1 while step_cnt ≠ 0, and step_cnt decrements each such cycle. A step_p during an active step is ignored. The breakpoint does not apply in PAUSED.
  - HALT: cpu_en = 0. halted clears only when filtered run falls (entering PAUSED). A run_p from PAUSED with pc still equal to brk_addr re-halts immediately.
- IO map (all writes require io_we):
  - 0x00 write: out0 ← io_dout[IN_W-1:0].
  - 0x04 read: io_din = {0, ready}.
  - 0x08 write: disp_reg ← io_dout.
  - 0x0C read: io_din = zero-extended sw_reg.
  - 0x10 write: ready ← 0 (acknowledge, data ignored).
  - 0x14 write: brk_addr ← io_dout, brk_valid ← 1. Writing 0xFFFFFFFF sets brk_valid ← 0 instead.
  - Other addresses: reads return 0, writes are ignored.
- Switch handshake: in RUN, valid_p sets sw_reg ← in and ready ← 1. A valid_p while ready = 1 is ignored, so sw_reg holds the unacknowledged value. If the 0x10 acknowledge and valid_p land in the same cycle, the acknowledge wins.
- Check: in PAUSED or HALT, valid_p increments check mod 4. Check does not change in RUN.
- Display: the shown word is disp_reg in RUN and view_data otherwise. seg = word[4*an +: 4].

## Timing
- Reset: cpu_en 0, halted 0, check 0, out0 0, ready 0, an 0, seg 0, disp_reg 0, sw_reg 0, brk_valid 0, brk_addr 0, step_cnt 0, filtered levels 0, scan counter 0.
- Button-to-pulse latency: 2 + DB_CYCLES cycles after the raw input settles. Glitches shorter than DB_CYCLES produce nothing.
- Step: cpu_en rises on the cycle after step_p and stays high for exactly max(in, 1) cycles.
- IO writes take effect on the clock edge with io_we. io_din has zero latency.
- Scan: an advances every SCAN_DIV cycles, wrapping DIGITS-1 → 0. seg follows the word and an combinationally.
- Reset mid-step or in HALT returns everything to reset values immediately (asynchronous).

## Test plan
- Step count: DB_CYCLES=4, run = 0, in = 3, pulse step → cpu_en high for exactly 3 consecutive cycles, 7 cycles after the step rises. With in = 0 → exactly 1 cycle.
- Debounce: a 3-cycle step glitch → no cpu_en activity. A 10-cycle press → one step, not repeated.
- Breakpoint: write 0x14 ← 0x00000010, run = 1, pc ramps by 4 from 0 → cpu_en = 0 in the cycle pc = 0x10, halted = 1 next cycle. Run low → halted 0.
- Handshake: RUN, in = 0x15, valid → ready = 1, 0x0C reads 0x15. Second valid with in = 0x02 → sw_reg stays 0x15. Write 0x10 → ready = 0.
- Display and check: PAUSED, three valid pulses → check = 3. view_data = 0x89ABCDEF → seg sequence F,E,D,C,B,A,9,8 with an 0..7, each held 16 cycles, then wraps to an = 0.
- Reset: assert rst low during a 5-cycle step → cpu_en 0 and all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pdu_ctrl_pl.sv
// pdu_ctrl_pl: program-debug unit for the pipelined CPU.
// Debounced run/step/valid buttons, clock-enable gating with multi-cycle step
// and PC breakpoint, memory-mapped IO registers and a scanned hex display.

// Per-input conditioner: 2-flop synchroniser followed by a stability filter.
module pdu_db #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // Synchronise, then accept a new level only after DB_CYCLES equal samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module pdu_ctrl_pl #(
   parameter int DATA_W    = 32,
   parameter int IN_W      = 5,
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 16,
   parameter int DB_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       step,
   input  logic                       valid,
   input  logic [IN_W-1:0]            in,
   input  logic [DATA_W-1:0]          pc,
   input  logic [DATA_W-1:0]          view_data,
   input  logic [7:0]                 io_addr,
   input  logic [DATA_W-1:0]          io_dout,
   input  logic                       io_we,
   output logic [DATA_W-1:0]          io_din,
   output logic                       cpu_en,
   output logic                       halted,
   output logic [1:0]                 check,
   output logic [IN_W-1:0]            out0,
   output logic [$clog2(DIGITS)-1:0]  an,
   output logic [3:0]                 seg,
   output logic                       ready
);
   localparam int AW = $clog2(DIGITS);
   localparam int SW = $clog2(SCAN_DIV + 1);

   // Conditioned levels: [0] run, [1] step, [2] valid.
   logic [2:0]        lvl;
   logic [2:1]        lvl_q;
   logic              run_f, step_p, valid_p, mode_run, brk_hit;
   logic [IN_W-1:0]   step_cnt;
   logic [DATA_W-1:0] disp_reg, brk_addr, word;
   logic [IN_W-1:0]   sw_reg;
   logic              brk_valid;
   logic [SW-1:0]     div;
   logic [DIGITS-1:0][3:0] nib;

   pdu_db #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
      .clk   (clk),
      .rst   (rst),
      .raw   ({valid, step, run}),
      .level (lvl)
   );

   assign run_f    = lvl[0];
   assign step_p   = lvl[1] & ~lvl_q[1];
   assign valid_p  = lvl[2] & ~lvl_q[2];
   assign mode_run = run_f & ~halted;
   assign brk_hit  = brk_valid && (pc == brk_addr);

   // Delayed filtered levels for rising-edge pulse detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lvl_q <= '0;
      else      lvl_q <= lvl[2:1];
   end

   // Step counter: loaded on a step pulse while paused, counts down while enabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   step_cnt <= '0;
      else if (run_f)             step_cnt <= '0;
      else if (step_cnt != '0)    step_cnt <= step_cnt - 1'b1;
      else if (step_p)            step_cnt <= (in == '0) ? IN_W'(1) : in;
   end

   // Halt latch: set by a breakpoint hit in RUN, cleared only by leaving run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   halted <= 1'b0;
      else if (!run_f)            halted <= 1'b0;
      else if (brk_hit)           halted <= 1'b1;
   end

   // CPU clock enable; the breakpoint compare blocks the matching cycle itself.
   always_comb begin
      cpu_en = 1'b0;
      if (!run_f)       cpu_en = (step_cnt != '0);
      else if (!halted) cpu_en = !brk_hit;
   end

   // IO registers, switch handshake (acknowledge beats capture) and view selector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out0      <= '0;
         disp_reg  <= '0;
         brk_addr  <= '0;
         brk_valid <= 1'b0;
         sw_reg    <= '0;
         ready     <= 1'b0;
         check     <= '0;
      end else begin
         if (io_we && io_addr == 8'h00) out0     <= io_dout[IN_W-1:0];
         if (io_we && io_addr == 8'h08) disp_reg <= io_dout;
         if (io_we && io_addr == 8'h14) begin
            if (io_dout == '1) begin
               brk_valid <= 1'b0;
            end else begin
               brk_addr  <= io_dout;
               brk_valid <= 1'b1;
            end
         end
         if (io_we && io_addr == 8'h10) begin
            ready <= 1'b0;
         end else if (mode_run && valid_p && !ready) begin
            ready  <= 1'b1;
            sw_reg <= in;
         end
         if (!mode_run && valid_p) check <= check + 1'b1;
      end
   end

   // IO read mux, zero latency.
   always_comb begin
      io_din = '0;
      case (io_addr)
         8'h04:   io_din = {{(DATA_W-1){1'b0}}, ready};
         8'h0C:   io_din = DATA_W'(sw_reg);
         default: io_din = '0;
      endcase
   end

   // Digit scan: advance the active digit every SCAN_DIV cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= '0;
         an  <= '0;
      end else if (div == SW'(SCAN_DIV - 1)) begin
         div <= '0;
         an  <= (an == AW'(DIGITS - 1)) ? '0 : an + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Shown word: software display register in RUN, debug view otherwise.
   assign word = mode_run ? disp_reg : view_data;
   assign nib  = word[4*DIGITS-1:0];
   // Blank while reset is held so the display starts dark.
   assign seg  = rst ? nib[an] : 4'h0;
endmodule
